// File: rtl/vga_line_fetch_arbiter_if.sv
// Shared frame-memory port plus convolution-client request channel.
// master = arbiter side, slave = memory/convolution environment side.
interface vga_line_fetch_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, c_gnt, c_rvalid,
        input  mem_rdata, c_req, c_we, c_addr, c_wdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, c_gnt, c_rvalid,
        output mem_rdata, c_req, c_we, c_addr, c_wdata
    );
endinterface

// File: rtl/vga_line_fetch_arbiter.sv
// Line prefetch into a ping-pong buffer, sharing frame memory with the convolution engine.
// Optional CONV_ARB_FAIR_EN: C is granted one cycle after every 7 consecutive contended P grants.
module vga_line_fetch_arbiter #(
    parameter int unsigned       H_ACTIVE  = 640,
    parameter int unsigned       V_ACTIVE  = 480,
    parameter int unsigned       ADDR_W    = 19,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        line_start,
    vga_line_fetch_arbiter_if.master    bus,
    output logic                        lb_we,
    output logic                        lb_bank,
    output logic [9:0]                  lb_waddr,
    output logic [DATA_W-1:0]           lb_wdata,
    output logic                        disp_bank,
    output logic                        fetch_busy,
    output logic                        underrun
);
    localparam int unsigned       XW       = 10;
    localparam int unsigned       LCW      = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     XLast    = XW'(H_ACTIVE - 1);
    localparam logic [LCW-1:0]    LastLine = LCW'(V_ACTIVE - 1);
    localparam logic [LCW-1:0]    LineMax  = LCW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              fetch_bank_q, fetch_bank_d;
    logic [LCW-1:0]    line_cnt_q, line_cnt_d;
    logic              disp_bank_q, disp_bank_d;
    logic              underrun_q, underrun_d;
    logic              rd_pend_q, rd_bank_q, c_rvalid_q;
    logic [XW-1:0]     rd_x_q;
    logic              strobe, p_gnt, c_gnt, fair_stall;

    assign strobe = frame_start | line_start;
    // No prefetch issue in a strobe cycle: the fetch is being (re)started.
    assign p_gnt  = (state_q == StFetch) & ~strobe & ~fair_stall;
    assign c_gnt  = bus.c_req & ~p_gnt & ~reset;

`ifdef CONV_ARB_FAIR_EN
    logic [2:0] streak_q, streak_d;

    assign fair_stall = bus.c_req & (streak_q == 3'd7);

    always_comb begin
        streak_d = streak_q;
        if (state_q == StIdle || !bus.c_req || c_gnt) begin
            streak_d = '0;
        end else if (p_gnt) begin
            streak_d = streak_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign fair_stall = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        line_base_d  = line_base_q;
        fetch_bank_d = fetch_bank_q;
        line_cnt_d   = line_cnt_q;
        disp_bank_d  = disp_bank_q;
        underrun_d   = underrun_q;
        case (state_q)
            StFetch: begin
                if (p_gnt) begin
                    x_d = x_q + 1'b1;
                    if (x_q == XLast) state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            default: ;
        endcase
        if (frame_start) begin
            state_d      = StFetch;
            x_d          = '0;
            line_base_d  = BASE_ADDR;
            fetch_bank_d = 1'b0;
            line_cnt_d   = '0;
            disp_bank_d  = 1'b0;
        end else if (line_start) begin
            if (state_q != StIdle) underrun_d = 1'b1;
            disp_bank_d = line_cnt_q[0];
            if (line_cnt_q != LineMax) line_cnt_d = line_cnt_q + 1'b1;
            if (line_cnt_q < LastLine) begin
                state_d      = StFetch;
                x_d          = '0;
                fetch_bank_d = ~line_cnt_q[0];
                line_base_d  = line_base_q + LineStep;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            line_base_q  <= BASE_ADDR;
            fetch_bank_q <= 1'b0;
            line_cnt_q   <= '0;
            disp_bank_q  <= 1'b0;
            underrun_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_x_q       <= '0;
            rd_bank_q    <= 1'b0;
            c_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            line_base_q  <= line_base_d;
            fetch_bank_q <= fetch_bank_d;
            line_cnt_q   <= line_cnt_d;
            disp_bank_q  <= disp_bank_d;
            underrun_q   <= underrun_d;
            rd_pend_q    <= p_gnt;
            c_rvalid_q   <= c_gnt & ~bus.c_we;
            if (p_gnt) begin
                rd_x_q    <= x_q;
                rd_bank_q <= fetch_bank_q;
            end
        end
    end

    always_comb begin
        bus.mem_req   = p_gnt | c_gnt;
        bus.mem_we    = c_gnt & bus.c_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (p_gnt) begin
            bus.mem_addr = line_base_q + ADDR_W'(x_q);
        end else if (c_gnt) begin
            bus.mem_addr  = bus.c_addr;
            bus.mem_wdata = bus.c_wdata;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.c_rvalid = c_rvalid_q;

    // A strobe aborts the fetch, so the read landing this cycle is dropped.
    assign lb_we      = rd_pend_q & ~strobe;
    assign lb_bank    = rd_bank_q;
    assign lb_waddr   = rd_x_q;
    assign lb_wdata   = lb_we ? bus.mem_rdata : '0;
    assign disp_bank  = disp_bank_q;
    assign fetch_busy = (state_q != StIdle);
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
// Randomized bench for vga_line_fetch_arbiter against a line/pixel-level reference model.
module tb_vga_line_fetch_arbiter;
    localparam int unsigned       H    = 640;
    localparam int unsigned       V    = 4;
    localparam int unsigned       AW   = 19;
    localparam int unsigned       DW   = 8;
    localparam logic [AW-1:0]     BASE = 19'h01230;

    logic          clk = 1'b0;
    logic          reset, frame_start, line_start;
    logic          lb_we, lb_bank, disp_bank, fetch_busy, underrun;
    logic [9:0]    lb_waddr;
    logic [DW-1:0] lb_wdata;

    vga_line_fetch_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_line_fetch_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .bus(bus), .lb_we(lb_we), .lb_bank(lb_bank), .lb_waddr(lb_waddr),
        .lb_wdata(lb_wdata), .disp_bank(disp_bank), .fetch_busy(fetch_busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int c_mode   = 0;  // 0: no C traffic, 1: c_req held high, 2: random C traffic

    // Reference model: phase 0 idle, 1 fetching, 2 draining.
    int m_phase, m_x, m_line, m_bank, m_lcnt, m_disp, m_under, m_streak;
    int m_pend, m_pend_x, m_pend_bank, m_crv;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_x = 0; m_line = 0; m_bank = 0; m_lcnt = 0; m_disp = 0;
        m_under = 0; m_streak = 0; m_pend = 0; m_pend_x = 0; m_pend_bank = 0; m_crv = 0;
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.c_gnt, bus.c_rvalid,
                lb_we, lb_bank, lb_waddr, lb_wdata, disp_bank, fetch_busy, underrun};
    endfunction

    task automatic check_cycle();
        bit strobe, stall, p, cg, elb;
        logic [AW-1:0] ea;
        strobe = frame_start || line_start;
        stall  = 1'b0;
`ifdef CONV_ARB_FAIR_EN
        stall  = bus.c_req && (m_streak == 7);
`endif
        p   = (m_phase == 1) && !strobe && !stall;
        cg  = bus.c_req && !p;
        ea  = p ? AW'(int'(BASE) + m_line * H + m_x) : bus.c_addr;
        elb = (m_pend != 0) && !strobe;
        check_eq("mem_req", bus.mem_req, p || cg);
        check_eq("mem_we", bus.mem_we, cg && bus.c_we);
        if (p || cg) check_eq("mem_addr", bus.mem_addr, ea);
        if (cg && bus.c_we) check_eq("mem_wdata", bus.mem_wdata, bus.c_wdata);
        check_eq("c_gnt", bus.c_gnt, cg);
        check_eq("c_rvalid", bus.c_rvalid, m_crv != 0);
        check_eq("lb_we", lb_we, elb);
        if (elb) begin
            check_eq("lb_bank", lb_bank, m_pend_bank != 0);
            check_eq("lb_waddr", lb_waddr, m_pend_x);
            check_eq("lb_wdata", lb_wdata, bus.mem_rdata);
        end
        check_eq("status", {disp_bank, fetch_busy, underrun},
                 {m_disp != 0, m_phase != 0, m_under != 0});
        // Advance the model to the next cycle.
        m_crv = cg && !bus.c_we;
        m_pend = p; m_pend_x = m_x; m_pend_bank = m_bank;
        if (m_phase == 0 || !bus.c_req || cg) m_streak = 0;
        else if (p) m_streak++;
        if (p) begin
            if (m_x == H - 1) m_phase = 2;
            m_x++;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end
        if (frame_start) begin
            m_phase = 1; m_x = 0; m_line = 0; m_bank = 0; m_lcnt = 0; m_disp = 0;
        end else if (line_start) begin
            if (m_phase != 0) m_under = 1;
            m_disp = m_lcnt % 2;
            if (m_lcnt < V - 1) begin
                m_phase = 1; m_x = 0; m_line = m_lcnt + 1; m_bank = (m_lcnt + 1) % 2;
            end else begin
                m_phase = 0;
            end
            m_lcnt++;
        end
    endtask

    task automatic drive_c();
        bus.mem_rdata = DW'($urandom);
        bus.c_we      = 1'($urandom);
        bus.c_addr    = AW'($urandom);
        bus.c_wdata   = DW'($urandom);
        case (c_mode)
            0:       bus.c_req = 1'b0;
            1:       bus.c_req = 1'b1;
            default: bus.c_req = 1'($urandom);
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        drive_c();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.mem_rdata = '0;
        model_reset();
        #1;
        check_eq("reset_outs", all_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run(3);

        // Frame preload with an idle convolution client.
        frame_start = 1'b1;
        run(700);
        // Line 1 fetch with random C traffic, then line 2 with C held busy.
        c_mode = 2; line_start = 1'b1; run(700);
        c_mode = 1; line_start = 1'b1; run(301);
        // Early strobe mid-fetch: underrun, restart on the next line.
        line_start = 1'b1; run(700);
        // Simultaneous strobes: frame_start wins.
        frame_start = 1'b1; line_start = 1'b1; run(700);
        // Walk through the remaining lines, including the last (no fetch).
        c_mode = 2;
        repeat (V) begin
            line_start = 1'b1;
            run(700);
        end

        // Random strobe timing, keeping line_start within a frame's V lines.
        repeat (12000) begin
            if (m_lcnt < V && $urandom_range(0, 399) == 0) line_start = 1'b1;
            if ($urandom_range(0, 1999) == 0 || (m_lcnt >= V && $urandom_range(0, 299) == 0))
                frame_start = 1'b1;
            c_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
            tick();
        end

        // Asynchronous reset in the middle of a fetch with C requesting.
        c_mode = 1; frame_start = 1'b1; run(100);
        bus.c_req = 1'b1;
        bus.mem_rdata = 8'hA5;
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run(20);
        frame_start = 1'b1; run(660);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
